wrr_arbiter: RTL and testbench
==============================

WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; SHALL support N >= 2, not necessarily a power of two.
REQ-002 Parameter WW, default 4: width of each per-requester weight field.
REQ-003 Localparam M = max(1, clog2(N)): index width.
REQ-004 i_clk  input  1: single clock; all state updates on its rising edge.
REQ-005 i_rstn  input  1: asynchronous, active-low reset.
REQ-006 i_en  input  1: arbitration enable; when low, all state and outputs hold.
REQ-007 i_mode  input  1: 0 = plain round-robin with 1-cycle grants; 1 = weighted round-robin.
REQ-008 i_req  input  N: request vector, bit i = requester i.
REQ-009 i_weight  input  N*WW: weight of requester i in bits [i*WW +: WW].
REQ-010 o_gnt  output  N: registered one-hot grant, or all-zero.
REQ-011 o_gnt_idx  output  M: index of the granted requester; 0 when o_gnt is 0.
REQ-012 o_busy  output  1: high while a grant is held (state GRANT).

Function
REQ-013 States: IDLE (no owner) and GRANT (owner k, remaining-credit counter cnt, WW bits).
REQ-014 Pick rule: the winner is the first set bit of i_req scanning upward from ptr, with wrap-around modulo N (ptr has the highest priority).
REQ-015 IDLE, i_en=1, i_req!=0: go to GRANT with the picked owner; o_gnt is valid the next cycle (1-cycle latency); cnt loads eff_w-1.
REQ-016 eff_w = i_weight[owner] if i_mode=1 and that weight is nonzero; otherwise 1 (zero weight counts as 1; i_mode=0 forces 1).
REQ-017 The weight is sampled only when a grant is issued; later changes do not affect the grant in progress.
REQ-018 IDLE, i_en=1, i_req=0: stay in IDLE; o_gnt=0; ptr unchanged.
REQ-019 GRANT (owner k), i_en=1, i_req[k]=1, cnt>0: hold the grant and decrement cnt.
REQ-020 GRANT (owner k), i_en=1, and either i_req[k]=0 or cnt=0: release, in this order:
- set ptr = k+1, wrapping N-1 to 0;
- in the same cycle, pick from the current i_req using the new ptr (no bubble cycle);
- if a winner exists, issue a new grant and load its counter;
- otherwise go to IDLE and clear o_gnt.
REQ-021 Under REQ-020 the old owner may win again only if it is the sole requester; it then gets a fresh credit load.
REQ-022 i_en=0: ptr, state, cnt, o_gnt, o_gnt_idx and o_busy hold their values; i_req is ignored.
REQ-023 o_gnt SHALL never have more than one bit set; o_gnt_idx and o_busy SHALL always match o_gnt.
REQ-024 The counter never underflows; the maximum hold is 2^WW-1 consecutive cycles.

Reset
REQ-025 While i_rstn=0: state=IDLE, ptr=0, cnt=0, o_gnt=0, o_gnt_idx=0, o_busy=0, regardless of the clock.
REQ-026 Reset asserted mid-grant aborts the grant immediately.
REQ-027 The first arbitration after reset release starts from ptr=0.

Structure
REQ-028 Package wrr_arbiter_pkg SHALL hold the state enum (IDLE, GRANT) and the default parameter constants.
REQ-029 The rotating first-set pick (REQ-014) SHALL be a combinational sub-module rr_pick, parametrised by N, with outputs one-hot, index and any-valid.
REQ-030 All registers SHALL live in a single always_ff block with asynchronous reset.

Verification
REQ-031 N=4, i_mode=0, i_req=1111 held with i_en=1: o_gnt cycles 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-032 N=4, i_mode=1, weights {1,2,3,4}, i_req=1111: requesters 0,1,2,3 hold the grant for 1,2,3,4 cycles, repeating with period 10.
REQ-033 i_mode=1, weight[2]=5, only req2 high; drop req2 after 2 grant cycles with req0 high: release without a bubble, o_gnt=0001 next cycle, ptr=3.
REQ-034 Sole requester 1 with weight 0, i_mode=1: o_gnt=0010 is re-granted every cycle, each time with a 1-cycle credit.
REQ-035 Hold i_en low for 3 cycles mid-grant (cnt=2): outputs frozen; on re-enable, 2 more hold cycles follow before release.
REQ-036 Assert i_rstn low mid-grant with o_gnt=0100: o_gnt=0 and o_busy=0 immediately; after release with i_req=1111, the first grant is 0001.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and default sizing for the weighted round-robin arbiter.
// Holds the arbiter state encoding and the index-width helper.
package wrr_arbiter_pkg;

  localparam int WRR_N_DEFAULT  = 4;
  localparam int WRR_WW_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } wrr_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating first-set picker: finds the first asserted request at or above
// ptr_i, wrapping modulo N. Purely combinational; N need not be a power of two.
module rr_pick
  import wrr_arbiter_pkg::*;
#(
  parameter int N = WRR_N_DEFAULT,
  localparam int M = idx_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [M-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [M-1:0] idx_o,
  output logic         vld_o
);

  // One extra bit so ptr + offset (at most 2N-2) never overflows before the wrap.
  logic [M:0] pos;

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (M+1)'(i);
      if (pos >= (M+1)'(N)) begin
        pos = pos - (M+1)'(N);
      end
      if (!vld_o && req_i[pos[M-1:0]]) begin
        vld_o = 1'b1;
        idx_o = pos[M-1:0];
      end
    end
  end

  assign gnt_o = vld_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-owner credit
// counter loaded from the owner's weight, and back-to-back handover on release.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int N  = WRR_N_DEFAULT,
  parameter int WW = WRR_WW_DEFAULT,
  localparam int M = idx_width(N)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  input  logic          i_mode,
  input  logic [N-1:0]  i_req,
  input  logic [N*WW-1:0] i_weight,
  output logic [N-1:0]  o_gnt,
  output logic [M-1:0]  o_gnt_idx,
  output logic          o_busy
);

  wrr_state_e    state_q, state_d;
  logic [M-1:0]  ptr_q,   ptr_d;
  logic [M-1:0]  owner_q, owner_d;
  logic [WW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  gnt_q,   gnt_d;

  logic          release_c;
  logic [M-1:0]  owner_inc;
  logic [M-1:0]  pick_ptr;
  logic [N-1:0]  pick_gnt;
  logic [M-1:0]  pick_idx;
  logic          pick_vld;
  logic [WW-1:0] w_sel;
  logic [WW-1:0] credit_load;

  assign owner_inc = (owner_q == M'(N-1)) ? '0 : owner_q + 1'b1;
  assign release_c = (state_q == ST_GRANT) && (!i_req[owner_q] || (cnt_q == '0));

  // On release the search starts just past the old owner, so it only wins
  // again when nobody else is requesting.
  assign pick_ptr  = release_c ? owner_inc : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req_i (i_req),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == M'(i)) begin
        w_sel = i_weight[i*WW +: WW];
      end
    end
  end

  // Zero weight and plain round-robin both collapse to a single-cycle grant.
  assign credit_load = (i_mode && (w_sel != '0)) ? w_sel - 1'b1 : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    if (i_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_d = ST_GRANT;
            owner_d = pick_idx;
            cnt_d   = credit_load;
            gnt_d   = pick_gnt;
          end
        end
        ST_GRANT: begin
          if (!release_c) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            ptr_d = owner_inc;
            if (pick_vld) begin
              owner_d = pick_idx;
              cnt_d   = credit_load;
              gnt_d   = pick_gnt;
            end else begin
              state_d = ST_IDLE;
              owner_d = '0;
              cnt_d   = '0;
              gnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          owner_d = '0;
          cnt_d   = '0;
          gnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_idx = owner_q;
  assign o_busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Randomized and directed bench for wrr_arbiter, checked against a
// cycle-level reference model of the arbitration rules.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int M  = 2;

  logic          clk;
  logic          rstn;
  logic          en;
  logic          mode;
  logic [N-1:0]  req;
  logic [N*WW-1:0] weight;
  logic [N-1:0]  gnt;
  logic [M-1:0]  gnt_idx;
  logic          busy;

  int n_chk;
  int n_pass;

  // Reference model: owner, cycles of grant still to be served, pointer.
  bit m_busy;
  int m_owner;
  int m_left;
  int m_ptr;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_en      (en),
    .i_mode    (mode),
    .i_req     (req),
    .i_weight  (weight),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int off = 0; off < N; off++) begin
      if (r[(from + off) % N]) return (from + off) % N;
    end
    return -1;
  endfunction

  function automatic int eff_w(input int k);
    int w;
    w = int'(weight[k*WW +: WW]);
    return (mode && w != 0) ? w : 1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0;
  endtask

  task automatic model_grant_or_idle(input int w);
    if (w >= 0) begin
      m_busy = 1; m_owner = w; m_left = eff_w(w);
    end else begin
      m_busy = 0; m_owner = 0; m_left = 0;
    end
  endtask

  task automatic model_step();
    if (!m_busy) begin
      model_grant_or_idle(pick(req, m_ptr));
    end else if (req[m_owner] && m_left > 1) begin
      m_left--;
    end else begin
      m_ptr = (m_owner + 1) % N;
      model_grant_or_idle(pick(req, m_ptr));
    end
  endtask

  task automatic check_model();
    check("gnt",    32'(gnt),     m_busy ? 32'(1) << m_owner : 32'd0);
    check("idx",    32'(gnt_idx), m_busy ? 32'(m_owner) : 32'd0);
    check("busy",   32'(busy),    32'(m_busy));
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    if (en) model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int seq[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};

  initial begin
    n_chk = 0; n_pass = 0;
    rstn = 1'b0; en = 1'b1; mode = 1'b0; req = '0; weight = '0;
    model_reset();
    do_reset();

    // Plain round-robin with everyone requesting.
    mode = 1'b0; req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      check("rr_seq", 32'(gnt), 32'(1) << (c % 4));
    end

    // Weighted 1,2,3,4 with period 10.
    do_reset();
    mode = 1'b1; weight = {4'd4, 4'd3, 4'd2, 4'd1}; req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      check("wrr_seq", 32'(gnt), 32'(1) << seq[c % 10]);
    end

    // Early drop of the owner hands over without a bubble.
    do_reset();
    mode = 1'b1; weight = {4'd1, 4'd5, 4'd1, 4'd1}; req = 4'b0100;
    step(); step();
    check("drop_hold", 32'(gnt), 32'h4);
    req = 4'b0001;
    step();
    check("drop_next", 32'(gnt), 32'h1);
    req = 4'b1001;
    step();
    check("drop_ptr", 32'(gnt), 32'h8);

    // Sole requester with zero weight gets single-cycle credits.
    do_reset();
    mode = 1'b1; weight = {4'd7, 4'd7, 4'd0, 4'd7}; req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      check("zw_regrant", 32'(gnt), 32'h2);
    end
    req = 4'b0011;
    step();
    check("zw_credit1", 32'(gnt), 32'h1);

    // Enable low freezes a grant with two credits remaining.
    do_reset();
    mode = 1'b1; weight = {4'd1, 4'd1, 4'd1, 4'd5}; req = 4'b0001;
    step(); step(); step();
    en = 1'b0; req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      check("en_freeze", 32'(gnt), 32'h1);
    end
    en = 1'b1; req = 4'b0011;
    step(); check("en_hold1", 32'(gnt), 32'h1);
    step(); check("en_hold2", 32'(gnt), 32'h1);
    step(); check("en_release", 32'(gnt), 32'h2);

    // Asynchronous reset mid-grant aborts it; arbitration restarts at 0.
    do_reset();
    mode = 1'b1; weight = {4'd4, 4'd3, 4'd2, 4'd1}; req = 4'b1111;
    for (int c = 0; c < 4; c++) step();
    check("pre_rst", 32'(gnt), 32'h4);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check("post_rst", 32'(gnt), 32'h1);

    // Random traffic with occasional disables, mode flips and resets.
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 9) == 0) weight = 16'($urandom);
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
